// File: rtl/ripple_adder.sv
// ---------------------------------------------------------------------------
// ripple_adder
//
// Registered WIDTH-bit ripple-carry adder for the ALU datapath. A chain of
// 1-bit full-adder cells produces {carry-out, sum} = a + b + c_in. The
// result is captured in output registers when in_valid is high, so
// downstream stages see a stable, synchronous result one cycle later.
//
// Optional feature macro: ADD_RIPPLE_OVF_EN
//   When defined, adds the registered two's-complement overflow flag ovf,
//   computed as carry[WIDTH] ^ carry[WIDTH-1] (for WIDTH=1 this is
//   carry[1] ^ c_in).
//
// Parameters:
//   WIDTH      operand and sum width in bits, 1 to 32 (default 3)
//
// Ports:
//   clk        input   system clock, rising edge active
//   rst        input   synchronous reset, active-high; wins over in_valid
//   in_valid   input   qualifies a, b, c_in for capture on this edge
//   a          input   [WIDTH-1:0] addend A, unsigned
//   b          input   [WIDTH-1:0] addend B, unsigned
//   c_in       input   carry into bit 0
//   sum        output  [WIDTH-1:0] registered sum
//   c_out      output  registered carry out of bit WIDTH-1
//   out_valid  output  one-cycle pulse per accepted input
//   ovf        output  registered signed overflow (ADD_RIPPLE_OVF_EN only)
// ---------------------------------------------------------------------------

// One full-adder cell of the carry chain.
module ripple_adder_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_next
);
    logic p;

    // Propagate term is shared by the sum and the carry equations.
    assign p      = a ^ b;
    assign s      = p ^ c;
    assign c_next = (a & b) | (c & p);
endmodule

module ripple_adder #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef ADD_RIPPLE_OVF_EN
    output logic             out_valid,
    output logic             ovf
`else
    output logic             out_valid
`endif
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             valid_reg;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            ripple_adder_fa u_fa (
                .a      (a[gi]),
                .b      (b[gi]),
                .c      (carry[gi]),
                .s      (sum_next[gi]),
                .c_next (carry[gi+1])
            );
        end
    endgenerate

    // Result registers only load on an accepted input, so whatever sits on
    // the operand pins while in_valid is low (including X/Z) cannot reach
    // the held outputs. out_valid is updated every cycle to form a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg   <= sum_next;
                c_out_reg <= carry[WIDTH];
            end
        end
    end

    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign out_valid = valid_reg;

`ifdef ADD_RIPPLE_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (in_valid) begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_ripple_adder
//
// Self-checking bench for ripple_adder (WIDTH=3). Each step drives inputs on
// the falling edge, updates a behavioural model from the adder's rules using
// plain integer arithmetic, and checks the registered outputs just after the
// following rising edge. Honours ADD_RIPPLE_OVF_EN for the ovf port.
// ---------------------------------------------------------------------------
module tb_ripple_adder;
    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             out_valid;
`ifdef ADD_RIPPLE_OVF_EN
    logic             ovf;
`endif

    int total;
    int bad;

    // Behavioural model state
    int exp_sum;
    int exp_cout;
    int exp_valid;
    int exp_ovf;

    ripple_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
`ifdef ADD_RIPPLE_OVF_EN
        .out_valid (out_valid),
        .ovf       (ovf)
`else
        .out_valid (out_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Signed value of a WIDTH-bit pattern.
    function automatic int as_signed(input int v);
        return (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
    endfunction

    // One clock: drive, advance the model, check after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input int av, input int bv, input int cv);
        int total_val;
        int s_signed;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av[WIDTH-1:0];
        b        = bv[WIDTH-1:0];
        c_in     = cv[0];
        if (r) begin
            exp_sum = 0; exp_cout = 0; exp_valid = 0; exp_ovf = 0;
        end else if (v) begin
            total_val = av + bv + cv;
            exp_sum   = total_val % (1 << WIDTH);
            exp_cout  = total_val / (1 << WIDTH);
            s_signed  = as_signed(av) + as_signed(bv) + cv;
            exp_ovf   = (s_signed > (1 << (WIDTH - 1)) - 1 ||
                         s_signed < -(1 << (WIDTH - 1))) ? 1 : 0;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".sum"}, int'(sum), exp_sum);
        check_val({tag, ".c_out"}, int'(c_out), exp_cout);
        check_val({tag, ".out_valid"}, int'(out_valid), exp_valid);
`ifdef ADD_RIPPLE_OVF_EN
        check_val({tag, ".ovf"}, int'(ovf), exp_ovf);
`endif
        $display("step %-10s rst=%0b vld=%0b a=%0d b=%0d cin=%0d -> sum=%0d c_out=%0b out_valid=%0b",
                 tag, r, v, av, bv, cv, sum, c_out, out_valid);
    endtask

    initial begin
        total = 0; bad = 0;
        exp_sum = 0; exp_cout = 0; exp_valid = 0; exp_ovf = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;

        // Reset held with a live input: reset must win.
        step("reset0", 1'b1, 1'b1, 7, 7, 1);
        step("reset1", 1'b1, 1'b1, 7, 7, 1);

        // Directed cases
        step("basic", 1'b0, 1'b1, 3, 2, 0);
        step("ripple", 1'b0, 1'b1, 7, 0, 1);
        step("max", 1'b0, 1'b1, 7, 7, 1);
        step("ovf", 1'b0, 1'b1, 3, 1, 0);
        step("hold_ld", 1'b0, 1'b1, 3, 5, 0);
        step("hold", 1'b0, 1'b0, 1, 1, 0);
        step("hold2", 1'b0, 1'b0, 7, 7, 1);

        // X on operands while idle must not disturb held outputs.
        @(negedge clk);
        in_valid = 1'b0; a = 'x; b = 'x; c_in = 1'bx;
        exp_valid = 0;
        @(posedge clk);
        #1;
        check_val("x_hold.sum", int'(sum), exp_sum);
        check_val("x_hold.c_out", int'(c_out), exp_cout);
        check_val("x_hold.out_valid", int'(out_valid), exp_valid);
        $display("step x_hold    a/b/cin=X -> sum=%0d c_out=%0b out_valid=%0b",
                 sum, c_out, out_valid);

        // Exhaustive back-to-back stream; out_valid must stay high.
        for (int i = 0; i < 128; i++) begin
            step("exh", 1'b0, 1'b1, (i >> 4) & 7, (i >> 1) & 7, i & 1);
        end

        // Reset mid-stream discards the in-flight result.
        step("pre_rst", 1'b0, 1'b1, 6, 5, 1);
        step("mid_rst", 1'b1, 1'b1, 4, 4, 0);
        step("post_rst", 1'b0, 1'b0, 2, 2, 0);
        step("first_v", 1'b0, 1'b1, 2, 3, 1);

        // Randomized mix of valid/idle cycles with occasional reset.
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
